dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the byte-addressed data memory: combinational 32-bit little-endian read, write on posedge clk.
- Port 0 is the CPU load/store path (single-word accesses). Port 1 is the DNN accelerator, which issues single words or auto-incrementing bursts.
- Arbitrates by round-robin, checks alignment and bounds, drives the single memory port, and returns registered responses.

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arbiter_rr_arb2.sv | 23 ++
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types, sizes and access-legality check for the data-memory arbiter
package dmem_arb_pkg;

    typedef enum logic {IDLE, BURST} state_e;

    localparam int unsigned WORD_BYTES    = 4;
    localparam int unsigned MEM_LAST_BYTE = 500;
    localparam int unsigned MAX_BURST     = 16;

    function automatic logic acc_legal(input logic [31:0] addr, input int unsigned words,
                                       input int unsigned last_byte);
        logic [32:0] end_x;
        end_x = {1'b0, addr} + 33'(words * WORD_BYTES);
        return (addr[1:0] == 2'b00) && (end_x <= 33'(last_byte) + 33'd1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; last winner loses the next tie, port 0 wins the first
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       upd_win,
    output logic [1:0] gnt
);

    logic last_q, last_d;

    always_comb begin
        gnt    = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;
        last_d = update ? upd_win : last_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) last_q <= 1'b1;
        else      last_q <= last_d;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and burst sequencer for the CPU and DNN data-memory ports
module dmem_arbiter
    import dmem_arb_pkg::state_e, dmem_arb_pkg::IDLE, dmem_arb_pkg::BURST,
           dmem_arb_pkg::WORD_BYTES, dmem_arb_pkg::acc_legal;
#(
    parameter int unsigned MEM_LAST_BYTE = dmem_arb_pkg::MEM_LAST_BYTE,
    parameter int unsigned MAX_BURST     = dmem_arb_pkg::MAX_BURST,
    parameter int unsigned LEN_W         = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    output logic             m0_gnt,
    output logic             m0_ack,
    output logic [31:0]      m0_rdata,
    output logic             m0_err,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [31:0]      m1_addr,
    input  logic [LEN_W-1:0] m1_len,
    input  logic [31:0]      m1_wdata,
    output logic             m1_gnt,
    output logic             m1_ack,
    output logic [31:0]      m1_rdata,
    output logic             m1_err,
    output logic             m1_done,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_we,
    input  logic [31:0]      mem_rdata
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      baddr_q, baddr_d;
    logic             bwe_q, bwe_d;
    logic             m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
    logic [31:0]      m0_rdata_q, m0_rdata_d;
    logic             m1_ack_q, m1_ack_d, m1_err_q, m1_err_d, m1_done_q, m1_done_d;
    logic [31:0]      m1_rdata_q, m1_rdata_d;

    logic [1:0]       arb_req, arb_gnt;
    logic             arb_upd, arb_win;
    logic [LEN_W-1:0] len_eff;
    logic             m0_ok, m1_ok, idle, g0, g1, last_beat, start_burst;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .update  (arb_upd),
        .upd_win (arb_win),
        .gnt     (arb_gnt)
    );

    always_comb begin
        len_eff     = (m1_len == '0) ? LEN_W'(1) : m1_len;
        m0_ok       = acc_legal(m0_addr, 1, MEM_LAST_BYTE);
        m1_ok       = (32'(len_eff) <= MAX_BURST) && acc_legal(m1_addr, 32'(len_eff), MEM_LAST_BYTE);
        idle        = (state_q == IDLE);
        arb_req     = idle ? {m1_req, m0_req} : 2'b00;
        g0          = rst && idle && arb_gnt[0];
        g1          = rst && idle && arb_gnt[1];
        last_beat   = !idle && (cnt_q == LEN_W'(1));
        start_burst = g1 && m1_ok && (len_eff != LEN_W'(1));
        // A finished burst hands the next tie to port 0, which was stalled throughout
        arb_upd     = (idle && m0_req && m1_req) || last_beat;
        arb_win     = last_beat ? 1'b1 : arb_gnt[1];
        m0_gnt      = g0;
        m1_gnt      = g1 || (rst && !idle);
        mem_addr    = !idle ? baddr_q : (g1 ? m1_addr : m0_addr);
        mem_wdata   = (!idle || g1) ? m1_wdata : m0_wdata;
        mem_we      = rst && (!idle ? bwe_q : (g1 ? (m1_we && m1_ok) : (g0 && m0_we && m0_ok)));
        state_d     = start_burst ? BURST : (last_beat ? IDLE : state_q);
        cnt_d       = start_burst ? len_eff - LEN_W'(1) : (!idle ? cnt_q - LEN_W'(1) : cnt_q);
        baddr_d     = start_burst ? m1_addr + 32'(WORD_BYTES) : (!idle ? baddr_q + 32'(WORD_BYTES) : baddr_q);
        bwe_d       = start_burst ? m1_we : bwe_q;
        m0_ack_d    = g0;
        m0_err_d    = g0 && !m0_ok;
        m0_rdata_d  = (g0 && !m0_we && m0_ok) ? mem_rdata : m0_rdata_q;
        m1_ack_d    = m1_gnt;
        m1_err_d    = g1 && !m1_ok;
        m1_done_d   = (g1 && (!m1_ok || len_eff == LEN_W'(1))) || (rst && last_beat);
        m1_rdata_d  = ((g1 && !m1_we && m1_ok) || (rst && !idle && !bwe_q)) ? mem_rdata : m1_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            baddr_q    <= '0;
            bwe_q      <= 1'b0;
            m0_ack_q   <= 1'b0;
            m0_err_q   <= 1'b0;
            m0_rdata_q <= '0;
            m1_ack_q   <= 1'b0;
            m1_err_q   <= 1'b0;
            m1_done_q  <= 1'b0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            baddr_q    <= baddr_d;
            bwe_q      <= bwe_d;
            m0_ack_q   <= m0_ack_d;
            m0_err_q   <= m0_err_d;
            m0_rdata_q <= m0_rdata_d;
            m1_ack_q   <= m1_ack_d;
            m1_err_q   <= m1_err_d;
            m1_done_q  <= m1_done_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign m0_ack   = m0_ack_q;
    assign m0_err   = m0_err_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_ack   = m1_ack_q;
    assign m1_err   = m1_err_q;
    assign m1_done  = m1_done_q;
    assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a queued-expectation monitor for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m0_gnt, m0_ack, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [4:0]  m1_len = '0;
    logic        m1_gnt, m1_ack, m1_err, m1_done;
    logic [31:0] m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        logic        done;
        logic        chk_rd;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [7:0] mem [0:511];

    dmem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_ack    (m0_ack),
        .m0_rdata  (m0_rdata),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_len    (m1_len),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_ack    (m1_ack),
        .m1_rdata  (m1_rdata),
        .m1_err    (m1_err),
        .m1_done   (m1_done),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rb(input logic [31:0] a);
        return (a < 32'd512) ? mem[a[8:0]] : 8'h00;
    endfunction

    always_comb mem_rdata = {rb(mem_addr + 32'd3), rb(mem_addr + 32'd2), rb(mem_addr + 32'd1), rb(mem_addr)};

    always @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (mem_addr + 32'(b) < 32'd512) mem[9'(mem_addr + 32'(b))] <= mem_wdata[8*b +: 8];
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
        mem[16] <= 8'hEF; mem[17] <= 8'hBE; mem[18] <= 8'hAD; mem[19] <= 8'hDE;
        mem[32] <= 8'h78; mem[33] <= 8'h56; mem[34] <= 8'h34; mem[35] <= 8'h12;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    task automatic push0(input logic [31:0] rd, input logic err, input logic crd);
        exp_t e;
        e.cyc = cyc; e.rdata = rd; e.err = err; e.done = 1'b0; e.chk_rd = crd;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [31:0] rd, input logic err, input logic done, input logic crd);
        exp_t e;
        e.cyc = cyc; e.rdata = rd; e.err = err; e.done = done; e.chk_rd = crd;
        q1.push_back(e);
    endtask

    task automatic set0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set1(input logic r, input logic w, input logic [31:0] a, input logic [4:0] l,
                        input logic [31:0] d);
        m1_req = r; m1_we = w; m1_addr = a; m1_len = l; m1_wdata = d;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic gnts(input string name, input logic g0, input logic g1);
        chk({name, "_m0_gnt"}, m0_gnt, g0);
        chk({name, "_m1_gnt"}, m1_gnt, g1);
    endtask

    // Response monitor: every ack must match the oldest expectation, exactly one cycle after its grant
    always @(negedge clk) begin
        if (m0_ack) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL m0_ack_unexpected: got ack=1 expected no ack");
            end else begin
                e0 = q0.pop_front();
                chk("m0_ack_latency", cyc - e0.cyc, 1);
                chk("m0_err", m0_err, e0.err);
                if (e0.chk_rd) chk("m0_rdata", m0_rdata, e0.rdata);
            end
        end else if (q0.size() > 0 && q0[0].cyc < cyc - 1) begin
            void'(q0.pop_front());
            checks++; errors++;
            $display("FAIL m0_ack_missing: got ack=0 expected ack=1");
        end
        if (m1_ack) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL m1_ack_unexpected: got ack=1 expected no ack");
            end else begin
                e1 = q1.pop_front();
                chk("m1_ack_latency", cyc - e1.cyc, 1);
                chk("m1_err", m1_err, e1.err);
                chk("m1_done", m1_done, e1.done);
                if (e1.chk_rd) chk("m1_rdata", m1_rdata, e1.rdata);
            end
        end else begin
            chk("m1_done_without_ack", m1_done, 0);
            if (q1.size() > 0 && q1[0].cyc < cyc - 1) begin
                void'(q1.pop_front());
                checks++; errors++;
                $display("FAIL m1_ack_missing: got ack=0 expected ack=1");
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $finish;
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        set0(1, 1, 32'h100, 32'hFFFF_FFFF);
        smp();
        gnts("rst", 0, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_m0_ack", m0_ack, 0);
        chk("rst_m0_err", m0_err, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_ack", m1_ack, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_m1_done", m1_done, 0);

        nxt(); rst = 1'b1; set0(1, 0, 32'h10, 0);
        smp(); gnts("rd0", 1, 0); push0(32'hDEAD_BEEF, 0, 1);
        nxt(); set0(0, 0, 0, 0);
        smp();

        for (int i = 0; i < 3; i++) begin
            nxt(); set0(1, 0, 32'h10, 0); set1(1, 0, 32'h20, 1, 0);
            smp(); gnts("rr", i != 1, i == 1);
            if (i != 1) push0(32'hDEAD_BEEF, 0, 1);
            else        push1(32'h1234_5678, 0, 1, 1);
        end

        nxt(); set0(1, 0, 32'h40, 0); set1(1, 1, 32'h40, 4, 1);
        smp(); gnts("bw0", 0, 1);
        chk("bw0_mem_addr", mem_addr, 32'h40);
        chk("bw0_mem_we", mem_we, 1);
        push1(0, 0, 0, 0);
        for (int k = 1; k < 4; k++) begin
            nxt(); set1(0, 0, 0, 0, 32'(k + 1));
            smp(); gnts("bw", 0, 1);
            chk("bw_mem_addr", mem_addr, 32'h40 + 32'(4 * k));
            chk("bw_mem_wdata", mem_wdata, 32'(k + 1));
            chk("bw_mem_we", mem_we, 1);
            push1(0, 0, k == 3, 0);
        end
        nxt(); set1(1, 0, 32'h44, 1, 0);
        smp(); gnts("after_burst", 1, 0); push0(32'h1, 0, 1);
        nxt(); set0(0, 0, 0, 0);
        smp(); gnts("m1_after", 0, 1); push1(32'h2, 0, 1, 1);

        nxt(); set1(0, 0, 0, 0, 0); set0(1, 1, 32'h2, 32'hFFFF_FFFF);
        smp(); gnts("misalign", 1, 0); chk("misalign_mem_we", mem_we, 0); push0(0, 1, 0);
        nxt(); set0(0, 0, 0, 0); set1(1, 1, 32'd496, 2, 32'hFFFF_FFFF);
        smp(); gnts("oob", 0, 1); chk("oob_mem_we", mem_we, 0); push1(0, 1, 1, 0);
        nxt(); set1(1, 1, 32'h0, 17, 32'hFFFF_FFFF);
        smp(); gnts("len17", 0, 1); chk("len17_mem_we", mem_we, 0); push1(0, 1, 1, 0);
        nxt(); set1(0, 0, 0, 0, 0); set0(1, 0, 32'h0, 0);
        smp(); gnts("no_burst", 1, 0); push0(32'h0, 0, 1);

        nxt(); set0(1, 1, 32'd496, 32'hA5A5_A5A5);
        smp(); gnts("edge_wr", 1, 0); chk("edge_wr_mem_we", mem_we, 1); push0(0, 0, 0);
        nxt(); set0(1, 0, 32'd496, 0);
        smp(); gnts("edge_rd", 1, 0); push0(32'hA5A5_A5A5, 0, 1);

        nxt(); set0(0, 0, 0, 0); set1(1, 1, 32'h80, 8, 32'h11);
        smp(); gnts("rb1", 0, 1); chk("rb1_mem_we", mem_we, 1); push1(0, 0, 0, 0);
        nxt(); set1(0, 0, 0, 0, 32'h22);
        smp(); gnts("rb2", 0, 1); chk("rb2_mem_addr", mem_addr, 32'h84); push1(0, 0, 0, 0);
        nxt(); rst = 1'b0; set1(0, 0, 0, 0, 32'h33);
        smp(); gnts("rb3", 0, 0); chk("rb3_mem_we", mem_we, 0);
        nxt();
        smp(); gnts("rb4", 0, 0); chk("rb4_mem_we", mem_we, 0);
        chk("rb4_m1_ack", m1_ack, 0);
        nxt(); rst = 1'b1; set0(1, 0, 32'h80, 0);
        smp(); gnts("post_rst", 1, 0); push0(32'h11, 0, 1);
        nxt(); set0(1, 0, 32'h88, 0);
        smp(); gnts("dropped_beat", 1, 0); push0(32'h0, 0, 1);
        nxt(); set0(0, 0, 0, 0);
        repeat (3) smp();

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        summary();
        $finish;
    end

endmodule
